dial_cmd_parser: RTL and testbench

DIAL_CMD_PARSER -- requirements
Module: dial_cmd_parser

---
 rtl/dial_cmd_parser.sv | 182 ++++++++++++++++++
 tb/tb_dial_cmd_parser.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dial_cmd_parser.sv
// rtl/dial_cmd_parser.sv - ASCII L/R<n> line parser that feeds a dial rotator in chunks of at most 100 steps
module dial_cmd_parser (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        cmd_start,
    output logic        cmd_direction,
    output logic [6:0]  cmd_distance,
    input  logic        cmd_busy,
    output logic [15:0] line_count,
    output logic [7:0]  err_count,
    output logic        done
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_DIGITS,
        S_ISSUE,
        S_WAIT,
        S_SKIP,
        S_FIN
    } state_t;

    localparam logic [7:0]  CH_L      = 8'h4C;
    localparam logic [7:0]  CH_R      = 8'h52;
    localparam logic [7:0]  CH_LF     = 8'h0A;
    localparam logic [7:0]  CH_CR     = 8'h0D;
    localparam logic [13:0] MAX_CHUNK = 14'd100;

    state_t      r_state;
    logic        r_dir;
    logic [13:0] r_acc;
    logic [2:0]  r_ndig;
    logic [13:0] r_rem;
    logic        r_ended;
    logic        r_wait_first;
    logic        r_start;
    logic        r_cmd_dir;
    logic [6:0]  r_cmd_dist;
    logic [15:0] r_line_cnt;
    logic [7:0]  r_err_cnt;

    logic        w_accept;
    logic        w_is_digit;
    logic        w_is_lf;
    logic        w_is_cr;
    logic        w_is_dir;
    logic        w_dig_err;
    logic        w_line_end;
    logic [13:0] w_acc_next;
    logic [13:0] w_end_val;
    logic [6:0]  w_chunk;
    logic [7:0]  w_err_inc;

    assign in_ready      = (r_state == S_IDLE) || (r_state == S_DIGITS) || (r_state == S_SKIP);
    assign done          = (r_state == S_FIN);
    assign cmd_start     = r_start;
    assign cmd_direction = r_cmd_dir;
    assign cmd_distance  = r_cmd_dist;
    assign line_count    = r_line_cnt;
    assign err_count     = r_err_cnt;

    assign w_accept   = in_valid && in_ready;
    assign w_is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign w_is_lf    = (in_data == CH_LF);
    assign w_is_cr    = (in_data == CH_CR);
    assign w_is_dir   = (in_data == CH_L) || (in_data == CH_R);
    assign w_acc_next = (r_acc * 14'd10) + {10'd0, in_data[3:0]};
    assign w_end_val  = w_is_digit ? w_acc_next : r_acc;
    assign w_chunk    = (r_rem > MAX_CHUNK) ? 7'd100 : r_rem[6:0];
    assign w_err_inc  = (r_err_cnt == 8'hFF) ? 8'hFF : r_err_cnt + 8'd1;

    // A final CR carrying in_last stands in for the newline, so it needs at least one digit.
    always_comb begin
        w_dig_err = 1'b1;
        if (w_is_digit)
            w_dig_err = (r_ndig == 3'd4);
        else if (w_is_cr)
            w_dig_err = in_last && (r_ndig == 3'd0);
        else if (w_is_lf)
            w_dig_err = (r_ndig == 3'd0);
    end

    assign w_line_end = !w_dig_err && (w_is_lf || in_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_dir        <= 1'b0;
            r_acc        <= '0;
            r_ndig       <= '0;
            r_rem        <= '0;
            r_ended      <= 1'b0;
            r_wait_first <= 1'b0;
            r_start      <= 1'b0;
            r_cmd_dir    <= 1'b0;
            r_cmd_dist   <= '0;
            r_line_cnt   <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc  <= '0;
                        r_ndig <= '0;
                        if (w_is_dir) begin
                            r_dir   <= (in_data == CH_R);
                            r_state <= in_last ? S_FIN : S_DIGITS;
                        end else if (w_is_lf || w_is_cr) begin
                            r_state <= in_last ? S_FIN : S_IDLE;
                        end else begin
                            r_err_cnt <= w_err_inc;
                            r_state   <= in_last ? S_FIN : S_SKIP;
                        end
                    end
                end
                S_DIGITS: begin
                    if (w_accept) begin
                        if (w_dig_err) begin
                            r_err_cnt <= w_err_inc;
                            r_acc     <= '0;
                            r_ndig    <= '0;
                            r_state   <= in_last ? S_FIN : S_SKIP;
                        end else if (w_line_end) begin
                            r_rem      <= w_end_val;
                            r_line_cnt <= r_line_cnt + 16'd1;
                            r_ended    <= in_last;
                            r_acc      <= '0;
                            r_ndig     <= '0;
                            if (w_end_val != 14'd0)
                                r_state <= S_ISSUE;
                            else
                                r_state <= in_last ? S_FIN : S_IDLE;
                        end else if (w_is_digit) begin
                            r_acc  <= w_acc_next;
                            r_ndig <= r_ndig + 3'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!cmd_busy) begin
                        r_start      <= 1'b1;
                        r_cmd_dir    <= r_dir;
                        r_cmd_dist   <= w_chunk;
                        r_rem        <= r_rem - {7'd0, w_chunk};
                        r_wait_first <= 1'b1;
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The rotator raises busy a cycle after the pulse, so the first WAIT cycle is blind.
                    r_wait_first <= 1'b0;
                    if (!r_wait_first && !cmd_busy) begin
                        if (r_rem != 14'd0)
                            r_state <= S_ISSUE;
                        else if (r_ended)
                            r_state <= S_FIN;
                        else
                            r_state <= S_IDLE;
                    end
                end
                S_SKIP: begin
                    if (w_accept) begin
                        if (in_last)
                            r_state <= S_FIN;
                        else if (w_is_lf)
                            r_state <= S_IDLE;
                    end
                end
                S_FIN: begin
                    r_state <= S_FIN;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dial_cmd_parser.sv
// tb/tb_dial_cmd_parser.sv - self-checking bench for dial_cmd_parser with a busy-flag rotator model
module tb_dial_cmd_parser;
    typedef logic [7:0] u8;

    typedef struct {
        string txt;
        bit    last;
        int    np;
        int    p0;
        int    p1;
        int    p2;
        int    lines;
        int    errs;
        bit    fin;
        bit    rdy;
    } vec_t;

    localparam u8 LF = 8'h0A;
    localparam u8 CR = 8'h0D;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        cmd_start;
    logic        cmd_direction;
    logic [6:0]  cmd_distance;
    logic        cmd_busy = 1'b0;
    logic [15:0] line_count;
    logic [7:0]  err_count;
    logic        done;

    int   total = 0;
    int   bad = 0;
    int   pulses[$];
    int   rot_len = 3;
    int   busy_cnt = 0;
    logic prev_start = 1'b0;
    logic last_dir = 1'b0;
    logic [6:0] last_dist = 7'd0;
    vec_t vt[9];

    dial_cmd_parser dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .cmd_start    (cmd_start),
        .cmd_direction(cmd_direction),
        .cmd_distance (cmd_distance),
        .cmd_busy     (cmd_busy),
        .line_count   (line_count),
        .err_count    (err_count),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Pulse monitor and rotator share one process so busy is sampled before it is updated.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            cmd_busy   = 1'b0;
            busy_cnt   = 0;
            prev_start = 1'b0;
            last_dir   = 1'b0;
            last_dist  = 7'd0;
        end else begin
            if (cmd_start) begin
                chk("start_while_busy", int'(cmd_busy), 0);
                chk("start_back_to_back", int'(prev_start), 0);
                pulses.push_back(int'(cmd_direction) * 1000 + int'(cmd_distance));
                last_dir  = cmd_direction;
                last_dist = cmd_distance;
                cmd_busy  = 1'b1;
                busy_cnt  = rot_len;
            end else begin
                chk("cmd_hold", int'({cmd_direction, cmd_distance}), int'({last_dir, last_dist}));
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) cmd_busy = 1'b0;
                end
            end
            prev_start = cmd_start;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pulses.delete();
    endtask

    function automatic void str2q(input string s, output u8 q[$]);
        q.delete();
        for (int i = 0; i < s.len(); i++) q.push_back(u8'(s[i]));
    endfunction

    task automatic send_stream(input u8 b[$], input bit use_last, input int max_gap);
        int g;
        int guard;
        for (int i = 0; i < b.size(); i++) begin
            g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            repeat (g) @(negedge clk);
            in_valid = 1'b1;
            in_data  = b[i];
            in_last  = use_last && (i == b.size() - 1);
            guard = 0;
            while (!in_ready && guard < 20000) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) begin
                chk("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic settle();
        int quiet = 0;
        int n = 0;
        while (quiet < 6 && n < 20000) begin
            @(negedge clk);
            n++;
            if ((in_ready || done) && !cmd_busy && !cmd_start) quiet++;
            else quiet = 0;
        end
        chk("settle_timeout", int'(quiet >= 6), 1);
    endtask

    task automatic check_end(input string tag, input int ep[$], input int nl, input int ne, input bit fin);
        chk({tag, " pulse_count"}, pulses.size(), ep.size());
        for (int i = 0; i < ep.size() && i < pulses.size(); i++)
            chk({tag, " pulse"}, pulses[i], ep[i]);
        chk({tag, " line_count"}, int'(line_count), nl);
        chk({tag, " err_count"}, int'(err_count), ne);
        chk({tag, " done"}, int'(done), int'(fin));
        chk({tag, " in_ready"}, int'(in_ready), int'(!fin));
    endtask

    function automatic void gen_line(output u8 l[$]);
        int t;
        int n;
        u8  d;
        l.delete();
        t = $urandom_range(0, 9);
        d = ($urandom_range(0, 1) != 0) ? 8'h52 : 8'h4C;
        if (t <= 4) begin
            n = $urandom_range(1, 4);
            l.push_back(d);
            for (int k = 0; k < n; k++)
                l.push_back(8'h30 + u8'((k == 0 && n == 4) ? $urandom_range(0, 1) : $urandom_range(0, 9)));
            if ($urandom_range(0, 3) == 0) l.push_back(CR);
            l.push_back(LF);
        end else if (t == 5) begin
            if ($urandom_range(0, 1) != 0) l.push_back(CR);
            l.push_back(LF);
        end else if (t == 6) begin
            l.push_back(($urandom_range(0, 1) != 0) ? 8'h78 : 8'h35);
            l.push_back(8'h37);
            l.push_back(LF);
        end else if (t == 7) begin
            l.push_back(d);
            if ($urandom_range(0, 1) != 0) l.push_back(CR);
            l.push_back(LF);
        end else if (t == 8) begin
            l.push_back(d);
            for (int k = 0; k < 5; k++) l.push_back(8'h31 + u8'(k));
            l.push_back(LF);
        end else begin
            l.push_back(d);
            l.push_back(8'h34);
            l.push_back(8'h61);
            l.push_back(LF);
        end
    endfunction

    // Line-oriented reference: split at LF, judge each line whole, expand values into <=100 chunks.
    function automatic void model(input u8 s[$], input bit use_last, output int ep[$],
                                  output int lines, output int errs, output bit fin);
        u8  cur[$];
        bit skip;
        bit term;
        bit have;
        bit badc;
        int k;
        int nd;
        int val;
        int dir;
        int ch;
        ep.delete();
        lines = 0;
        errs  = 0;
        skip  = 1'b0;
        for (int i = 0; i <= s.size(); i++) begin
            term = (i < s.size()) && (s[i] == LF);
            have = term || (i == s.size() && cur.size() > 0);
            if (i < s.size() && !term) begin
                cur.push_back(s[i]);
                continue;
            end
            if (!have) continue;
            if (skip) begin
                skip = 1'b0;
            end else begin
                k = 0;
                while (k < cur.size() && cur[k] == CR) k++;
                if (k < cur.size()) begin
                    if (cur[k] != 8'h4C && cur[k] != 8'h52) begin
                        errs++;
                    end else begin
                        dir  = (cur[k] == 8'h52) ? 1 : 0;
                        nd   = 0;
                        val  = 0;
                        badc = 1'b0;
                        for (int j = k + 1; j < cur.size(); j++) begin
                            if (cur[j] == CR) continue;
                            if (cur[j] >= 8'h30 && cur[j] <= 8'h39) begin
                                nd++;
                                val = val * 10 + int'(cur[j] - 8'h30);
                            end else begin
                                badc = 1'b1;
                            end
                        end
                        if (badc || nd > 4) begin
                            errs++;
                        end else if (nd == 0) begin
                            if (term) begin
                                errs++;
                                skip = 1'b1;
                            end else if (k + 1 < cur.size()) begin
                                errs++;
                            end
                        end else begin
                            lines++;
                            while (val > 0) begin
                                ch = (val > 100) ? 100 : val;
                                ep.push_back(dir * 1000 + ch);
                                val -= ch;
                            end
                        end
                    end
                end
            end
            cur.delete();
        end
        if (errs > 255) errs = 255;
        fin = use_last;
    endfunction

    initial begin
        u8  q[$];
        int ep[$];
        int nl;
        int ne;
        bit fin;
        bit ul;
        int wguard;

        vt[0] = '{txt:"L68\n",              last:1'b0, np:1, p0:68,   p1:0,    p2:0,    lines:1, errs:0, fin:1'b0, rdy:1'b0};
        vt[1] = '{txt:"R250\n",             last:1'b0, np:3, p0:1100, p1:1100, p2:1050, lines:1, errs:0, fin:1'b0, rdy:1'b0};
        vt[2] = '{txt:"X12\nR5\n",          last:1'b0, np:1, p0:1005, p1:0,    p2:0,    lines:1, errs:1, fin:1'b0, rdy:1'b0};
        vt[3] = '{txt:"L0\nR12345\n",       last:1'b0, np:0, p0:0,    p1:0,    p2:0,    lines:1, errs:1, fin:1'b0, rdy:1'b1};
        vt[4] = '{txt:"L3",                 last:1'b1, np:1, p0:3,    p1:0,    p2:0,    lines:1, errs:0, fin:1'b1, rdy:1'b0};
        vt[5] = '{txt:"\015\nL\0154\015\n", last:1'b0, np:1, p0:4,    p1:0,    p2:0,    lines:1, errs:0, fin:1'b0, rdy:1'b0};
        vt[6] = '{txt:"L\nR7\nL2\n",        last:1'b0, np:1, p0:2,    p1:0,    p2:0,    lines:1, errs:1, fin:1'b0, rdy:1'b0};
        vt[7] = '{txt:"L101\n",             last:1'b0, np:2, p0:100,  p1:1,    p2:0,    lines:1, errs:0, fin:1'b0, rdy:1'b0};
        vt[8] = '{txt:"Q",                  last:1'b1, np:0, p0:0,    p1:0,    p2:0,    lines:0, errs:1, fin:1'b1, rdy:1'b0};

        do_reset();
        chk("rst in_ready", int'(in_ready), 1);
        chk("rst cmd_start", int'(cmd_start), 0);
        chk("rst cmd_direction", int'(cmd_direction), 0);
        chk("rst cmd_distance", int'(cmd_distance), 0);
        chk("rst line_count", int'(line_count), 0);
        chk("rst err_count", int'(err_count), 0);
        chk("rst done", int'(done), 0);

        for (int v = 0; v < 9; v++) begin
            rot_len = 3;
            do_reset();
            str2q(vt[v].txt, q);
            send_stream(q, vt[v].last, 0);
            chk($sformatf("vec%0d ready_after_last_byte", v), int'(in_ready), int'(vt[v].rdy));
            settle();
            ep.delete();
            if (vt[v].np > 0) ep.push_back(vt[v].p0);
            if (vt[v].np > 1) ep.push_back(vt[v].p1);
            if (vt[v].np > 2) ep.push_back(vt[v].p2);
            check_end($sformatf("vec%0d", v), ep, vt[v].lines, vt[v].errs, vt[v].fin);
        end

        // Reset landing in WAIT of a multi-chunk line.
        rot_len = 4;
        do_reset();
        str2q("R250\n", q);
        send_stream(q, 1'b0, 0);
        wguard = 0;
        while (pulses.size() == 0 && wguard < 200) begin
            @(negedge clk);
            wguard++;
        end
        chk("midrst first_pulse_seen", int'(pulses.size() > 0), 1);
        if (pulses.size() > 0) chk("midrst first_pulse", pulses[0], 1100);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst cmd_start", int'(cmd_start), 0);
        chk("midrst cmd_direction", int'(cmd_direction), 0);
        chk("midrst cmd_distance", int'(cmd_distance), 0);
        chk("midrst line_count", int'(line_count), 0);
        chk("midrst err_count", int'(err_count), 0);
        chk("midrst done", int'(done), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        pulses.delete();
        chk("midrst in_ready_after_release", int'(in_ready), 1);
        repeat (30) @(negedge clk);
        chk("midrst no_more_pulses", pulses.size(), 0);
        str2q("L1\n", q);
        send_stream(q, 1'b0, 0);
        settle();
        ep.delete();
        ep.push_back(1);
        check_end("midrst next_stream", ep, 1, 0, 1'b0);

        // err_count saturation at 255.
        rot_len = 2;
        do_reset();
        q.delete();
        for (int i = 0; i < 255; i++) begin
            q.push_back(8'h5A);
            q.push_back(LF);
        end
        send_stream(q, 1'b0, 0);
        chk("sat err_at_255", int'(err_count), 255);
        str2q("Z\nZ\nZ\nZ\nZ\nR5\n", q);
        send_stream(q, 1'b0, 0);
        settle();
        ep.delete();
        ep.push_back(1005);
        check_end("sat", ep, 1, 255, 1'b0);

        for (int it = 0; it < 30; it++) begin
            u8  l[$];
            int n;
            q.delete();
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                gen_line(l);
                foreach (l[m]) q.push_back(l[m]);
            end
            ul = ($urandom_range(0, 1) != 0);
            if (ul && $urandom_range(0, 1) != 0 && q.size() > 1) void'(q.pop_back());
            model(q, ul, ep, nl, ne, fin);
            rot_len = $urandom_range(1, 5);
            do_reset();
            send_stream(q, ul, 2);
            settle();
            check_end($sformatf("rnd%0d", it), ep, nl, ne, fin);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
